// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and hazard status out.
// master drives the ID side and control (flush/hold); slave is the pipeline register itself.
interface id_ex_pipe_reg_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [6:0]            id_opcode;
  logic [7:0]            id_ctrl;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [3:0]            id_funct;
  logic                  flush;
  logic                  hold;

  logic                  ex_valid;
  logic [7:0]            ex_ctrl;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [3:0]            ex_funct;
  logic                  id_stall;
  logic                  illegal;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output id_valid, id_opcode, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, flush, hold,
    input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, id_stall, illegal, bubble_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, flush, hold,
    output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, id_stall, illegal, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold and illegal-opcode squash.
// Optional macro BUBBLE_COUNT_EN builds the saturating load-use bubble counter; otherwise bubble_cnt is 0.
module id_ex_pipe_reg #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  id_ex_pipe_reg_if.slave    bus
);

  localparam logic [6:0] op_rtype = 7'b0110011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_beq   = 7'b1100011;

  logic                  is_r, is_ld, is_sd, is_beq;
  logic                  legal, uses_rs2, load_use;
  logic                  capture, squash_illegal;

  logic                  ex_valid_r;
  logic [7:0]            ex_ctrl_r;
  logic [XLEN-1:0]       ex_pc_r, ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
  logic [REG_ADDR_W-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r;
  logic [3:0]            ex_funct_r;
  logic                  illegal_r;

  assign is_r     = (bus.id_opcode == op_rtype);
  assign is_ld    = (bus.id_opcode == op_load);
  assign is_sd    = (bus.id_opcode == op_store);
  assign is_beq   = (bus.id_opcode == op_beq);
  assign legal    = is_r | is_ld | is_sd | is_beq;
  assign uses_rs2 = is_r | is_sd | is_beq;

  // Every legal opcode reads rs1; loads are the only ones that ignore rs2.
  assign load_use = ex_valid_r & ex_ctrl_r[4] & (ex_rd_r != '0) & bus.id_valid & legal &
                    ((ex_rd_r == bus.id_rs1) | (uses_rs2 & (ex_rd_r == bus.id_rs2)));

  assign bus.id_stall = (load_use | bus.hold) & ~bus.flush;

  assign capture        = ~bus.flush & ~bus.hold & ~load_use & bus.id_valid & legal;
  assign squash_illegal = ~bus.flush & ~bus.hold & bus.id_valid & ~legal;

  // Hold (without flush) is the only case that neither captures nor inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r    <= 1'b0;
      ex_ctrl_r     <= '0;
      ex_pc_r       <= '0;
      ex_rs1_data_r <= '0;
      ex_rs2_data_r <= '0;
      ex_imm_r      <= '0;
      ex_rs1_r      <= '0;
      ex_rs2_r      <= '0;
      ex_rd_r       <= '0;
      ex_funct_r    <= '0;
    end else if (capture) begin
      ex_valid_r    <= 1'b1;
      ex_ctrl_r     <= bus.id_ctrl;
      ex_pc_r       <= bus.id_pc;
      ex_rs1_data_r <= bus.id_rs1_data;
      ex_rs2_data_r <= bus.id_rs2_data;
      ex_imm_r      <= bus.id_imm;
      ex_rs1_r      <= bus.id_rs1;
      ex_rs2_r      <= bus.id_rs2;
      ex_rd_r       <= bus.id_rd;
      ex_funct_r    <= bus.id_funct;
    end else if (bus.flush || !bus.hold) begin
      ex_valid_r    <= 1'b0;
      ex_ctrl_r     <= '0;
      ex_pc_r       <= '0;
      ex_rs1_data_r <= '0;
      ex_rs2_data_r <= '0;
      ex_imm_r      <= '0;
      ex_rs1_r      <= '0;
      ex_rs2_r      <= '0;
      ex_rd_r       <= '0;
      ex_funct_r    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_r <= 1'b0;
    else        illegal_r <= squash_illegal;
  end

`ifdef BUBBLE_COUNT_EN
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_q <= '0;
    else if (!bus.flush && !bus.hold && load_use && (bubble_q != '1))
      bubble_q <= bubble_q + 1'b1;
  end

  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.bubble_cnt = '0;
`endif

  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_ctrl     = ex_ctrl_r;
  assign bus.ex_pc       = ex_pc_r;
  assign bus.ex_rs1_data = ex_rs1_data_r;
  assign bus.ex_rs2_data = ex_rs2_data_r;
  assign bus.ex_imm      = ex_imm_r;
  assign bus.ex_rs1      = ex_rs1_r;
  assign bus.ex_rs2      = ex_rs2_r;
  assign bus.ex_rd       = ex_rd_r;
  assign bus.ex_funct    = ex_funct_r;
  assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load-use bubbles, flush/hold priority, illegal squash, counter saturation.
module tb_id_ex_pipe_reg;

  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W = 32;

`ifdef BUBBLE_COUNT_EN
  localparam bit cntEn = 1'b1;
`else
  localparam bit cntEn = 1'b0;
`endif

  localparam logic [6:0] opR   = 7'b0110011;
  localparam logic [6:0] opLd  = 7'b0000011;
  localparam logic [6:0] opSd  = 7'b0100011;
  localparam logic [6:0] opBeq = 7'b1100011;
  localparam logic [6:0] opImm = 7'b0010011;

  localparam logic [7:0] ctrlR   = 8'h22;
  localparam logic [7:0] ctrlLd  = 8'hF0;
  localparam logic [7:0] ctrlSd  = 8'h88;
  localparam logic [7:0] ctrlBeq = 8'h05;

  localparam logic [63:0] rs1Mask = 64'hA5A5_0000_0000_A5A5;
  localparam logic [63:0] rs2Mask = 64'h0000_5A5A_5A5A_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Data operands are derived from pc so every captured field is distinguishable.
  task automatic applyStimulus(input logic valid, input logic [6:0] op, input logic [7:0] ctrl,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [63:0] pc, input logic fl, input logic hd);
    bus.id_valid    = valid;
    bus.id_opcode   = op;
    bus.id_ctrl     = ctrl;
    bus.id_pc       = pc;
    bus.id_rs1_data = pc ^ rs1Mask;
    bus.id_rs2_data = pc ^ rs2Mask;
    bus.id_imm      = pc + 64'd16;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_funct    = rd[3:0];
    bus.flush       = fl;
    bus.hold        = hd;
  endtask

  task automatic checkEx(input string tag, input logic valid, input logic [7:0] ctrl, input logic [63:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    checkOutput({tag, ".valid"}, 64'(bus.ex_valid), 64'(valid));
    checkOutput({tag, ".ctrl"},  64'(bus.ex_ctrl),  64'(ctrl));
    checkOutput({tag, ".pc"},    bus.ex_pc,         pc);
    checkOutput({tag, ".rs1d"},  bus.ex_rs1_data,   valid ? (pc ^ rs1Mask) : 64'd0);
    checkOutput({tag, ".rs2d"},  bus.ex_rs2_data,   valid ? (pc ^ rs2Mask) : 64'd0);
    checkOutput({tag, ".imm"},   bus.ex_imm,        valid ? (pc + 64'd16) : 64'd0);
    checkOutput({tag, ".rs1"},   64'(bus.ex_rs1),   64'(rs1));
    checkOutput({tag, ".rs2"},   64'(bus.ex_rs2),   64'(rs2));
    checkOutput({tag, ".rd"},    64'(bus.ex_rd),    64'(rd));
    checkOutput({tag, ".funct"}, 64'(bus.ex_funct), valid ? 64'(rd[3:0]) : 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBubble(input string tag);
    checkEx(tag, 1'b0, 8'h00, 64'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // One ld x5 followed by a dependent add; ends with the add in EX.
  task automatic ldUsePair(input logic [63:0] pc);
    @(negedge clk); applyStimulus(1'b1, opLd, ctrlLd, 5'd8, 5'd0, 5'd5, pc, 1'b0, 1'b0);
    tick();
    @(negedge clk); applyStimulus(1'b1, opR, ctrlR, 5'd5, 5'd7, 5'd6, pc + 64'd4, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    tick();
  endtask

  initial begin
    applyStimulus(1'b0, 7'd0, 8'h00, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0);

    // Reset holds EX empty even with a valid instruction waiting in ID.
    @(negedge clk);
    applyStimulus(1'b1, opR, ctrlR, 5'd5, 5'd7, 5'd6, 64'h100, 1'b0, 1'b0);
    tick();
    checkBubble("rst");
    checkOutput("rst.illegal", 64'(bus.illegal), 64'd0);
    checkOutput("rst.cnt", 64'(bus.bubble_cnt), 64'd0);

    @(negedge clk); rst_n = 1'b1;
    tick();
    checkEx("t1.first", 1'b1, ctrlR, 64'h100, 5'd5, 5'd7, 5'd6);

    @(negedge clk); applyStimulus(1'b1, opR, ctrlR, 5'd1, 5'd2, 5'd3, 64'h104, 1'b0, 1'b0);
    tick();
    checkEx("t1.second", 1'b1, ctrlR, 64'h104, 5'd1, 5'd2, 5'd3);
    #2 rst_n = 1'b0;
    #1;
    checkBubble("t1.rstmid");
    checkOutput("t1.rstmid.illegal", 64'(bus.illegal), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(1'b1, opR, ctrlR, 5'd9, 5'd10, 5'd11, 64'h108, 1'b0, 1'b0);
    tick();
    checkEx("t1.afterrst", 1'b1, ctrlR, 64'h108, 5'd9, 5'd10, 5'd11);

    // ld x5 then add x6,x5,x7
    @(negedge clk); applyStimulus(1'b1, opLd, ctrlLd, 5'd8, 5'd0, 5'd5, 64'h200, 1'b0, 1'b0);
    tick();
    checkEx("t2.ld", 1'b1, ctrlLd, 64'h200, 5'd8, 5'd0, 5'd5);
    @(negedge clk); applyStimulus(1'b1, opR, ctrlR, 5'd5, 5'd7, 5'd6, 64'h204, 1'b0, 1'b0);
    #1 checkOutput("t2.stall", 64'(bus.id_stall), 64'd1);
    tick();
    checkBubble("t2.bubble");
    checkOutput("t2.stall_drop", 64'(bus.id_stall), 64'd0);
    checkOutput("t2.cnt", 64'(bus.bubble_cnt), cntEn ? 64'd1 : 64'd0);
    @(negedge clk);
    tick();
    checkEx("t2.add", 1'b1, ctrlR, 64'h204, 5'd5, 5'd7, 5'd6);
    checkOutput("t2.cnt_after", 64'(bus.bubble_cnt), cntEn ? 64'd1 : 64'd0);

    // ld x0 never creates a hazard
    @(negedge clk); applyStimulus(1'b1, opLd, ctrlLd, 5'd8, 5'd0, 5'd0, 64'h300, 1'b0, 1'b0);
    tick();
    @(negedge clk); applyStimulus(1'b1, opR, ctrlR, 5'd0, 5'd7, 5'd6, 64'h304, 1'b0, 1'b0);
    #1 checkOutput("t3.x0.stall", 64'(bus.id_stall), 64'd0);
    tick();
    checkEx("t3.x0.add", 1'b1, ctrlR, 64'h304, 5'd0, 5'd7, 5'd6);

    // ld ignores its rs2 field
    @(negedge clk); applyStimulus(1'b1, opLd, ctrlLd, 5'd8, 5'd0, 5'd5, 64'h400, 1'b0, 1'b0);
    tick();
    @(negedge clk); applyStimulus(1'b1, opLd, ctrlLd, 5'd8, 5'd5, 5'd6, 64'h404, 1'b0, 1'b0);
    #1 checkOutput("t3.ldrs2.stall", 64'(bus.id_stall), 64'd0);
    tick();
    checkEx("t3.ld2", 1'b1, ctrlLd, 64'h404, 5'd8, 5'd5, 5'd6);

    // beq reads rs2, so it stalls on ld x6; flush then overrides stall and hold
    @(negedge clk); applyStimulus(1'b1, opBeq, ctrlBeq, 5'd1, 5'd6, 5'd0, 64'h408, 1'b0, 1'b0);
    #1 checkOutput("t3.beq.stall", 64'(bus.id_stall), 64'd1);
    applyStimulus(1'b1, opBeq, ctrlBeq, 5'd1, 5'd6, 5'd0, 64'h408, 1'b1, 1'b1);
    #1 checkOutput("t4.flush.stall", 64'(bus.id_stall), 64'd0);
    tick();
    checkBubble("t4.flush");
    checkOutput("t4.cnt", 64'(bus.bubble_cnt), cntEn ? 64'd1 : 64'd0);

    // Illegal opcode is squashed and flagged for exactly one cycle
    @(negedge clk); applyStimulus(1'b1, opImm, 8'hFF, 5'd1, 5'd2, 5'd3, 64'h500, 1'b0, 1'b0);
    tick();
    checkBubble("t5.squash");
    checkOutput("t5.illegal", 64'(bus.illegal), 64'd1);
    @(negedge clk); applyStimulus(1'b0, opR, 8'hFF, 5'd1, 5'd2, 5'd3, 64'h504, 1'b0, 1'b0);
    tick();
    checkOutput("t5.illegal_drop", 64'(bus.illegal), 64'd0);
    checkBubble("t5.invalid");

    // Hold freezes sd in EX for three cycles
    @(negedge clk); applyStimulus(1'b1, opSd, ctrlSd, 5'd8, 5'd7, 5'd0, 64'h600, 1'b0, 1'b0);
    tick();
    checkEx("t6.sd", 1'b1, ctrlSd, 64'h600, 5'd8, 5'd7, 5'd0);
    @(negedge clk); applyStimulus(1'b1, opR, ctrlR, 5'd1, 5'd2, 5'd3, 64'h604, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("t6.hold.stall", 64'(bus.id_stall), 64'd1);
      tick();
      checkEx("t6.hold", 1'b1, ctrlSd, 64'h600, 5'd8, 5'd7, 5'd0);
      @(negedge clk);
    end
    applyStimulus(1'b1, opR, ctrlR, 5'd1, 5'd2, 5'd3, 64'h604, 1'b0, 1'b0);
    tick();
    checkEx("t6.release", 1'b1, ctrlR, 64'h604, 5'd1, 5'd2, 5'd3);

    // Load-use under hold is not counted until hold drops
    @(negedge clk); applyStimulus(1'b1, opLd, ctrlLd, 5'd8, 5'd0, 5'd5, 64'h700, 1'b0, 1'b0);
    tick();
    @(negedge clk); applyStimulus(1'b1, opR, ctrlR, 5'd5, 5'd7, 5'd6, 64'h704, 1'b0, 1'b1);
    tick();
    checkEx("t6.holdld", 1'b1, ctrlLd, 64'h700, 5'd8, 5'd0, 5'd5);
    checkOutput("t6.holdld.cnt", 64'(bus.bubble_cnt), cntEn ? 64'd1 : 64'd0);
    @(negedge clk); bus.hold = 1'b0;
    #1 checkOutput("t6.lu.stall", 64'(bus.id_stall), 64'd1);
    tick();
    checkBubble("t6.lu.bubble");
    checkOutput("t6.lu.cnt", 64'(bus.bubble_cnt), cntEn ? 64'd2 : 64'd0);
    @(negedge clk);
    tick();
    checkEx("t6.lu.add", 1'b1, ctrlR, 64'h704, 5'd5, 5'd7, 5'd6);

    // Counter saturation
`ifdef BUBBLE_COUNT_EN
    @(negedge clk);
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1 release dut.bubble_q;
`endif
    ldUsePair(64'h800);
    checkOutput("t6.sat1", 64'(bus.bubble_cnt), cntEn ? 64'h0000_0000_FFFF_FFFF : 64'd0);
    checkEx("t6.sat1.add", 1'b1, ctrlR, 64'h804, 5'd5, 5'd7, 5'd6);
    ldUsePair(64'h900);
    checkOutput("t6.sat2", 64'(bus.bubble_cnt), cntEn ? 64'h0000_0000_FFFF_FFFF : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
